// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath widths, arbiter FSM states.
// Pure declarations, no logic; imported by the arbiter and its bench.
// No flow control of its own.
package alu_pkg;

    localparam int ALU_W    = 4;
    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        NOT = 3'b101,
        SHR = 3'b110,
        SHL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    // One requester's operation, kept together so operand muxing stays one select.
    typedef struct packed {
        alu_op_t          op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, wrapping modulo NUM_REQ.
// Latency: zero, purely combinational.
// Backpressure: none; grant is all-zero when no req bit is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters, round-robin, one operation in flight.
// Latency: accept at E0, result captured at E0+ALU_LATENCY+1, resp_valid right after.
// Backpressure: resp_ready low parks the block in RESP with every req_ready low.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [4*NUM_REQ-1:0]     req_a,
    input  logic [4*NUM_REQ-1:0]     req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [ALU_W-1:0]         resp_result,
    output logic                     resp_carry,
    output logic                     busy,
    output logic [ALU_OP_W-1:0]      alu_op,
    output logic [ALU_W-1:0]         alu_a,
    output logic [ALU_W-1:0]         alu_b,
    input  logic [ALU_W-1:0]         alu_result,
    input  logic                     alu_carry
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [NUM_REQ-1:0] grant;
    logic             accept;
    alu_req_t         req_dat [NUM_REQ];
    alu_req_t         sel;
    alu_req_t         alu_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_dat[i] = '{
            op: alu_op_t'(req_op[ALU_OP_W*i +: ALU_OP_W]),
            a:  req_a[ALU_W*i +: ALU_W],
            b:  req_b[ALU_W*i +: ALU_W]
        };
    end

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel     = req_dat[grant_idx];
    assign accept  = (state == ST_IDLE) && (|req_valid);
    assign ptr_nxt = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign alu_op = alu_q.op;
    assign alu_a  = alu_q.a;
    assign alu_b  = alu_q.b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are forced low while reset is held so nothing is accepted or offered.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n) begin
                    req_ready = grant;
                end
                if (accept) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy = rst_n;
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                busy = rst_n;
                if (rst_n) begin
                    resp_valid[gid] = 1'b1;
                end
                if (resp_ready[gid]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            cnt         <= '0;
            gid         <= '0;
            alu_q       <= '0;
            resp_result <= '0;
            resp_carry  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_q  <= sel;
                        gid    <= grant_idx;
                        cnt    <= CNT_W'(ALU_LATENCY);
                        rr_ptr <= ptr_nxt;
                    end
                end
                ST_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_result <= alu_result;
                        resp_carry  <= alu_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors plus a random soak, with a
// second instance at ALU_LATENCY=3 for the latency check.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef logic [1:0] rid_t;
    typedef struct {
        rid_t       id;
        logic [3:0] res;
        logic       c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [11:0] req_op;
    logic [15:0] req_a, req_b;
    logic [3:0]  resp_result;
    logic        resp_carry, busy;
    logic [2:0]  alu_op;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic        alu_carry;
    logic [2:0]  op_v [4];
    logic [3:0]  a_v  [4];
    logic [3:0]  b_v  [4];

    logic [3:0]  req_valid3, req_ready3, resp_valid3, resp_ready3;
    logic [11:0] req_op3;
    logic [15:0] req_a3, req_b3;
    logic [3:0]  resp_result3;
    logic        resp_carry3, busy3;
    logic [2:0]  alu_op3;
    logic [3:0]  alu_a3, alu_b3, alu_result3;
    logic        alu_carry3;

    exp_t        exp_q[$];
    rid_t        accept_log[$];
    int          rr_order [5] = '{0, 1, 2, 3, 0};
    int          wait_cnt [4];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acc    = 0;
    int          n_resp   = 0;
    bit          soak_on  = 1'b0;

    always #5 clk = ~clk;

    assign req_op = {op_v[3], op_v[2], op_v[1], op_v[0]};
    assign req_a  = {a_v[3], a_v[2], a_v[1], a_v[0]};
    assign req_b  = {b_v[3], b_v[2], b_v[1], b_v[0]};

    alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_carry(resp_carry), .busy(busy),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_result(resp_result3), .resp_carry(resp_carry3), .busy(busy3),
        .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3), .alu_carry(alu_carry3)
    );

    // Reference ALU: carry is carry-out for ADD/SHL and borrow for SUB.
    function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        case (alu_op_t'(op))
            ADD:     t = {1'b0, a} + {1'b0, b};
            SUB:     t = {1'b0, a} - {1'b0, b};
            AND:     t = {1'b0, a & b};
            OR:      t = {1'b0, a | b};
            XOR:     t = {1'b0, a ^ b};
            NOT:     t = {1'b0, ~a};
            SHR:     t = {1'b0, a >> b};
            default: t = {1'b0, a} << b;
        endcase
        return t;
    endfunction

    logic [4:0] m1;
    logic [4:0] m3 [3];
    always @(posedge clk) begin
        m1    <= ref_alu(alu_op, alu_a, alu_b);
        m3[0] <= ref_alu(alu_op3, alu_a3, alu_b3);
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign {alu_carry, alu_result}   = m1;
    assign {alu_carry3, alu_result3} = m3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input rid_t i, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input bit model_exp);
        logic [4:0] r;
        int t;
        op_v[i] = op;
        a_v[i]  = a;
        b_v[i]  = b;
        req_valid[i] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready[i] && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("accept_within_budget", req_ready[i], 1);
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            return;
        end
        if (model_exp) begin
            r = ref_alu(op, a, b);
            exp_q.push_back('{i, r[3:0], r[4]});
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic soak_req(input rid_t i);
        for (int k = 0; k < 50; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            issue(i, 3'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: logs accepts, tracks waiting time, pops the scoreboard on every response handshake.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [3:0] ev;
        rid_t       acc;
        bit         hit;
        if (rst_n) begin
            hit = 1'b0;
            acc = '0;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[2'(i)] && req_ready[2'(i)]) begin
                    hit = 1'b1;
                    acc = 2'(i);
                end
            end
            if (hit) begin
                n_acc++;
                accept_log.push_back(acc);
                if (soak_on) begin
                    chk("no_starvation", 32'(wait_cnt[acc] > 3), 0);
                end
                wait_cnt[acc] = 0;
                for (int j = 0; j < 4; j++) begin
                    if (2'(j) != acc && req_valid[2'(j)]) begin
                        wait_cnt[j]++;
                    end
                end
            end
            if ((resp_valid & resp_ready) != 4'b0000) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_resp: got resp_valid %b, required no response", resp_valid);
                end else begin
                    e  = exp_q.pop_front();
                    ev = 4'b0001 << e.id;
                    chk("resp_valid_id", resp_valid, ev);
                    chk("resp_result", resp_result, e.res);
                    chk("resp_carry", resp_carry, e.c);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc0, resp0;
        rst_n      = 1'b0;
        req_valid  = 4'b0100;
        resp_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            op_v[i] = '0;
            a_v[i]  = '0;
            b_v[i]  = '0;
            wait_cnt[i] = 0;
        end
        req_valid3  = '0;
        req_op3     = '0;
        req_a3      = '0;
        req_b3      = '0;
        resp_ready3 = 4'hF;

        // Reset state, with a request already pending
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_resp_carry", resp_carry, 0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Single requester: ADD 9+8 -> 1 carry 1, response two cycles after accept
        @(posedge clk);
        #1;
        exp_q.push_back('{2'd0, 4'd1, 1'b1});
        op_v[0] = ADD;
        a_v[0]  = 4'd9;
        b_v[0]  = 4'd8;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("single_req_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("single_busy", busy, 1);
        chk("single_alu_op", alu_op, 0);
        chk("single_alu_a", alu_a, 9);
        chk("single_alu_b", alu_b, 8);
        @(posedge clk);
        #1;
        chk("single_resp_early", resp_valid, 0);
        @(posedge clk);
        #1;
        chk("single_resp_valid", resp_valid, 4'b0001);
        chk("single_result", resp_result, 1);
        chk("single_carry", resp_carry, 1);
        drain("single_drain");

        // Round robin from a fresh pointer, all four contending
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        accept_log.delete();
        exp_q.push_back('{2'd0, 4'd9,  1'b0});
        exp_q.push_back('{2'd1, 4'd8,  1'b0});
        exp_q.push_back('{2'd2, 4'd14, 1'b1});
        exp_q.push_back('{2'd3, 4'd10, 1'b0});
        exp_q.push_back('{2'd0, 4'd5,  1'b0});
        fork
            begin
                issue(2'd0, ADD, 4'd7, 4'd2, 1'b0);
                issue(2'd0, OR,  4'd4, 4'd1, 1'b0);
            end
            issue(2'd1, AND, 4'd12, 4'd10, 1'b0);
            issue(2'd2, SUB, 4'd3,  4'd5,  1'b0);
            issue(2'd3, XOR, 4'd5,  4'd15, 1'b0);
        join
        drain("rr_drain");
        chk("rr_accept_count", accept_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_order", accept_log[k], rr_order[k]);
        end

        // Backpressure on requester 1 while requester 0 waits
        exp_q.push_back('{2'd1, 4'd10, 1'b0});
        exp_q.push_back('{2'd0, 4'd2,  1'b0});
        resp_ready = 4'b1101;
        fork
            issue(2'd1, NOT, 4'd5, 4'd0, 1'b0);
            issue(2'd0, ADD, 4'd1, 4'd1, 1'b0);
            begin
                t = 0;
                @(negedge clk);
                while (!resp_valid[1] && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("bp_resp_rise", resp_valid[1], 1);
                repeat (10) begin
                    chk("bp_resp_valid", resp_valid, 4'b0010);
                    chk("bp_result", resp_result, 4'd10);
                    chk("bp_busy", busy, 1);
                    chk("bp_req_ready", req_ready, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                resp_ready = 4'hF;
                @(posedge clk);
                #1;
                chk("bp_release", resp_valid, 0);
            end
        join
        drain("bp_drain");

        // Reset during EXEC drops the operation and the pointer
        issue(2'd2, SHR, 4'd8, 4'd2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_req_ready", req_ready, 0);
        chk("rmid_resp_valid", resp_valid, 0);
        chk("rmid_alu_op", alu_op, 0);
        chk("rmid_alu_a", alu_a, 0);
        chk("rmid_alu_b", alu_b, 0);
        chk("rmid_resp_result", resp_result, 0);
        chk("rmid_resp_carry", resp_carry, 0);
        rst_n = 1'b1;
        accept_log.delete();
        exp_q.push_back('{2'd0, 4'd5, 1'b0});
        exp_q.push_back('{2'd3, 4'd5, 1'b0});
        fork
            issue(2'd3, ADD, 4'd2, 4'd3, 1'b0);
            issue(2'd0, XOR, 4'd6, 4'd3, 1'b0);
        join
        drain("rmid_drain");
        chk("rmid_first_grant", accept_log[0], 0);

        // Random soak with random response backpressure
        for (int i = 0; i < 4; i++) begin
            wait_cnt[i] = 0;
        end
        acc0    = n_acc;
        resp0   = n_resp;
        soak_on = 1'b1;
        fork
            begin
                fork
                    soak_req(2'd0);
                    soak_req(2'd1);
                    soak_req(2'd2);
                    soak_req(2'd3);
                join
                soak_on = 1'b0;
            end
            while (soak_on) begin
                @(posedge clk);
                #1;
                resp_ready = 4'($urandom);
            end
        join
        resp_ready = 4'hF;
        drain("soak_drain");
        chk("soak_accepts", n_acc - acc0, 200);
        chk("soak_responses", n_resp - resp0, 200);

        // ALU_LATENCY=3 instance: SHL 3 by 1 -> 6, response four cycles after accept
        @(posedge clk);
        #1;
        req_op3    = {9'd0, SHL};
        req_a3     = 16'h0003;
        req_b3     = 16'h0001;
        req_valid3 = 4'b0001;
        @(negedge clk);
        chk("lat3_req_ready", req_ready3, 4'b0001);
        @(posedge clk);
        #1;
        req_valid3 = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("lat3_resp_valid", resp_valid3, (k == 4) ? 4'b0001 : 4'b0000);
        end
        chk("lat3_result", resp_result3, 6);
        chk("lat3_carry", resp_carry3, 0);
        @(posedge clk);
        #1;
        chk("lat3_idle", busy3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 4-bit ALU (`synth_wrapper`) between `NUM_REQ` independent requesters. Requests use a valid/ready handshake and are granted round-robin. The block drives the ALU's `op`/`a`/`b` inputs from registers and waits the ALU's fixed latency. It then captures `result`/`carry` and returns them to the granted requester through a second valid/ready handshake. It sits directly in front of the ALU wrapper and is the only driver of its operand inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ALU_LATENCY`, default 1: clock edges from ALU inputs being applied to `result`/`carry` being valid, 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: request accepted this cycle, one-hot or zero.
- `req_op` in 3*NUM_REQ: opcode; requester i uses slice [3i+2:3i].
- `req_a` in 4*NUM_REQ: operand A; requester i uses slice [4i+3:4i].
- `req_b` in 4*NUM_REQ: operand B; requester i uses slice [4i+3:4i].
- `resp_valid` out NUM_REQ: response available, one-hot or zero.
- `resp_ready` in NUM_REQ: requester takes the response.
- `resp_result` out 4: result, shared by all requesters.
- `resp_carry` out 1: carry, shared by all requesters.
- `busy` out 1: high in any state other than IDLE.
- `alu_op` out 3: connects to ALU `op`.
- `alu_a` out 4: connects to ALU `a`.
- `alu_b` out 4: connects to ALU `b`.
- `alu_result` in 4: from ALU `result`.
- `alu_carry` in 1: from ALU `carry`.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Only one operation is in flight at a time.
- **IDLE**
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward modulo NUM_REQ.
  - `req_ready[grant]` = 1 combinationally; all other `req_ready` bits = 0.
  - On a handshake edge: `alu_op`/`alu_a`/`alu_b` ← the granted slices; `gid` ← grant; `cnt` ← ALU_LATENCY; `rr_ptr` ← (grant+1) mod NUM_REQ; go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE. `alu_*` keep their last values.
- **EXEC**
  - All `req_ready` = 0. `alu_*` are held stable.
  - While `cnt` ≠ 0, decrement `cnt` each edge.
  - On the edge with `cnt` = 0: `resp_result` ← `alu_result`, `resp_carry` ← `alu_carry`; go to RESP.
- **RESP**
  - `resp_valid[gid]` = 1; all other `resp_valid` bits = 0. `resp_result`/`resp_carry` are held.
  - On the edge where `resp_ready[gid]` = 1, go to IDLE.
  - `resp_ready` bits other than `resp_ready[gid]` are ignored.
- The opcode is passed through unchanged; all 8 codes are legal. The block does not range-check shift amounts; that is the ALU's concern.
- A requester must hold `req_valid` and its operands until accepted. If `req_valid` drops before acceptance, the arbiter simply re-arbitrates next cycle with no side effects.
- **Reset** (`rst_n` low at an edge), from any state:
  - State ← IDLE, `rr_ptr` ← 0, `cnt` ← 0, `gid` ← 0.
  - `alu_op`/`alu_a`/`alu_b` ← 0; `resp_result` ← 0; `resp_carry` ← 0.
  - Any in-flight operation is dropped with no response.
  - `req_ready`, `resp_valid` and `busy` read 0 while `rst_n` is low.

## Timing
- Accept at edge E0 → `alu_*` valid after E0 → result captured at edge E0+ALU_LATENCY+1 → `resp_valid` high after that edge.
- With the default latency: `resp_valid` is high 2 cycles after the accept edge.
- Minimum spacing between accepts is ALU_LATENCY+3 edges. This is reached when `resp_ready` is already high on entry to RESP.
- `resp_ready` held low stalls the block indefinitely in RESP, with all `req_ready` at 0.
- The IDLE grant is combinational from `req_valid` and `rr_ptr`. Every other output is registered or decoded from state.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t` enum, 3 bits: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SHR=110, SHL=111.
  - Constants `ALU_W`=4 and `ALU_OP_W`=3.
  - `arb_state_t` enum for the three FSM states.
- Sub-module `rr_arbiter` (parameter NUM_REQ): inputs `req` and `ptr`, outputs a one-hot `grant` and `grant_idx`. It is purely combinational and reusable.

## Test plan
- **Single requester.** Requester 0 issues ADD, a=9, b=8. Expect `req_ready[0]` at the first edge, `resp_valid[0]` 2 cycles later, result=1, carry=1.
- **Round-robin fairness.** All 4 requesters hold `req_valid`; `resp_ready` is tied high. Expect grant order 0,1,2,3,0. Each response matches that requester's op/a/b, e.g. req2 SUB a=3, b=5 gives result=14.
- **Response backpressure.** Hold `resp_ready[1]` low for 10 cycles after `resp_valid[1]` rises. Expect `resp_valid[1]`, `resp_result` and `busy` stable; no `req_ready` bit set; release acks on the next edge.
- **Reset mid-operation.** Assert `rst_n`=0 for one edge during EXEC. Expect IDLE, all outputs 0, no `resp_valid`, and next grant to requester 0.
- **Latency parameter.** Run with ALU_LATENCY=3 and a matching delayed ALU model, SHL a=3, b=1. Expect `resp_valid` 4 cycles after accept, result=6.
- **Random soak.** 200 random op/a/b requests across 4 requesters with random `resp_ready`. A scoreboard checks every result against a reference ALU model, one response per accepted request, and no starvation beyond 3 intervening grants.
